// File: rtl/vfp_exception_stage.sv
// Registered multi-lane exception/result select for the vector FP adder.
// Ports: in_valid/in_ready -> out_valid/out_ready handshake, per-lane operand
// and flag inputs, out_data {valid,mask,value} per lane (lane 0 in LSBs),
// sticky flags {OF,DN,ZC}, saturating of_count, clr_flags.
module vfp_exception_stage #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int LANES    = 4,
  parameter int INF_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0]                 lane_valid,
  input  logic [LANES-1:0]                 lane_mask,
  input  logic [LANES-1:0]                 sa,
  input  logic [LANES*EXP_W-1:0]           ea,
  input  logic [LANES*(MAN_W+1)-1:0]       ma,
  input  logic [LANES*(EXP_W+MAN_W)-1:0]   result,
  input  logic [LANES-1:0]                 den_flag,
  input  logic [LANES-1:0]                 dend_flag,
  input  logic [LANES*3-1:0]               inf_flag,
  input  logic [LANES-1:0]                 equals,
  input  logic [LANES-1:0]                 op_sign,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*(EXP_W+MAN_W+3)-1:0] out_data,
  output logic [2:0]                       flags,
  output logic [CNT_W-1:0]                 of_count,
  input  logic                             clr_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int LW = W + 2;

  logic              r_valid;
  logic [LANES*LW-1:0] r_data;
  logic [2:0]        r_flags;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_load;
  logic [LANES-1:0]  w_inf;
  logic [LANES-1:0]  w_q;
  logic [LANES-1:0]  w_of;
  logic [LANES-1:0]  w_dn;
  logic [LANES-1:0]  w_zc;
  logic [LANES*LW-1:0] w_next;
  logic [CNT_W:0]    w_ofn;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_cbase;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [2:0]        w_fbase;
  logic [2:0]        w_ev;

  assign in_ready  = ~r_valid | out_ready;
  assign w_load    = in_valid & in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign flags     = r_flags;
  assign of_count  = r_cnt;

  assign w_q = lane_valid & lane_mask;

  for (genvar g = 0; g < LANES; g++) begin : g_inf
    assign w_inf[g] = |inf_flag[3*g +: 3];
  end

  // Priority select per lane; events only for written, valid lanes.
  always_comb begin
    w_next = '0;
    w_of   = '0;
    w_dn   = '0;
    w_zc   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (den_flag[l] & ~dend_flag[l]) begin
        w_next[l*LW +: LW] = {lane_valid[l], lane_mask[l], sa[l],
                              ea[l*EXP_W +: EXP_W],
                              ma[l*(MAN_W+1) +: MAN_W]};
        w_dn[l] = w_q[l];
      end else if (w_inf[l]) begin
        // Legacy mode suppresses the write instead of encoding infinity.
        if (INF_MODE == 0)
          w_next[l*LW +: LW] = {1'b1, 1'b0, {W{1'b0}}};
        else
          w_next[l*LW +: LW] = {1'b1, lane_mask[l], sa[l],
                                {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_of[l] = w_q[l];
      end else if (equals[l] & ~op_sign[l]) begin
        w_next[l*LW +: LW] = {lane_valid[l], lane_mask[l], {W{1'b0}}};
        w_zc[l] = w_q[l];
      end else begin
        w_next[l*LW +: LW] = {lane_valid[l], lane_mask[l], sa[l],
                              result[l*(W-1) +: W-1]};
      end
    end
  end

  always_comb begin
    w_ofn = '0;
    for (int l = 0; l < LANES; l++)
      w_ofn = w_ofn + (CNT_W+1)'(w_of[l]);
  end

  // Clear-then-accumulate so a clear never loses same-cycle events.
  assign w_fbase  = clr_flags ? 3'b000 : r_flags;
  assign w_cbase  = clr_flags ? '0 : r_cnt;
  assign w_sum    = {1'b0, w_cbase} + w_ofn;
  assign w_cnt_nx = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign w_ev     = {|w_of, |w_dn, |w_zc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_flags <= 3'b000;
      r_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_data  <= w_next;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load) begin
        r_flags <= w_fbase | w_ev;
        r_cnt   <= w_cnt_nx;
      end else if (clr_flags) begin
        r_flags <= 3'b000;
        r_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vfp_exception_stage.sv
// Scoreboard bench for vfp_exception_stage, both overflow encodings.
// Reference model computes lane results and events from field values.
module tb_vfp_exception_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         clr_flags;
  logic [3:0]   lane_valid, lane_mask, sa, den_flag, dend_flag;
  logic [3:0]   equals, op_sign;
  logic [31:0]  ea;
  logic [95:0]  ma;
  logic [123:0] result;
  logic [11:0]  inf_flag;

  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [135:0] out_data0, out_data1;
  logic [2:0]   flags0, flags1;
  logic [15:0]  of_count0, of_count1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [135:0] q0[$];
  logic [135:0] q1[$];
  logic [135:0] p0, p1;
  logic [2:0]   p_ev;
  int           p_n;
  logic         tb_load = 1'b0;
  logic [2:0]   m_flags = 3'b000;
  int           m_cnt = 0;
  bit           run = 1'b0;

  always #5 clk = ~clk;

  vfp_exception_stage #(.INF_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .lane_valid(lane_valid), .lane_mask(lane_mask), .sa(sa), .ea(ea),
    .ma(ma), .result(result), .den_flag(den_flag), .dend_flag(dend_flag),
    .inf_flag(inf_flag), .equals(equals), .op_sign(op_sign),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .flags(flags0), .of_count(of_count0), .clr_flags(clr_flags)
  );

  vfp_exception_stage #(.INF_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .lane_valid(lane_valid), .lane_mask(lane_mask), .sa(sa), .ea(ea),
    .ma(ma), .result(result), .den_flag(den_flag), .dend_flag(dend_flag),
    .inf_flag(inf_flag), .equals(equals), .op_sign(op_sign),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .flags(flags1), .of_count(of_count1), .clr_flags(clr_flags)
  );

  task automatic chk(input string nm, input logic [135:0] act,
                     input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] lane_of(input logic [135:0] d, input int l);
    return d[l*34 +: 34];
  endfunction

  // 1 = denormal passthrough, 2 = overflow, 3 = cancellation, 4 = normal
  function automatic int cls(input int l);
    if (den_flag[l] && !dend_flag[l]) return 1;
    if (inf_flag[l*3 +: 3] != 3'b000) return 2;
    if (equals[l] && !op_sign[l]) return 3;
    return 4;
  endfunction

  function automatic logic [33:0] exp_lane(input int l, input int mode);
    logic [31:0] v;
    logic vb, mb;
    vb = lane_valid[l];
    mb = lane_mask[l];
    v = 32'h0;
    case (cls(l))
      1: v = (32'(sa[l]) << 31) | (32'(ea[l*8 +: 8]) << 23)
             | (32'(ma[l*24 +: 24]) & 32'h007F_FFFF);
      2: begin
        vb = 1'b1;
        if (mode == 0) begin mb = 1'b0; v = 32'h0; end
        else v = (32'(sa[l]) << 31) | 32'h7F80_0000;
      end
      3: v = 32'h0;
      default: v = (32'(sa[l]) << 31) | 32'(result[l*31 +: 31]);
    endcase
    return {vb, mb, v};
  endfunction

  task automatic defaults();
    lane_valid = 4'hF; lane_mask = 4'hF; sa = '0; ea = '0; ma = '0;
    result = '0; den_flag = '0; dend_flag = '0; inf_flag = '0;
    equals = '0; op_sign = '0;
  endtask

  task automatic rand_group();
    for (int l = 0; l < 4; l++) begin
      lane_valid[l] = ($urandom_range(0, 3) != 0);
      lane_mask[l]  = ($urandom_range(0, 3) != 0);
      sa[l]         = 1'($urandom_range(0, 1));
      ea[l*8 +: 8]  = 8'($urandom);
      ma[l*24 +: 24] = 24'($urandom);
      result[l*31 +: 31] = 31'($urandom);
      den_flag[l]   = ($urandom_range(0, 3) == 0);
      dend_flag[l]  = den_flag[l] ? 1'($urandom_range(0, 1))
                                  : ($urandom_range(0, 7) == 0);
      inf_flag[l*3 +: 3] = ($urandom_range(0, 3) == 0)
                           ? 3'($urandom_range(1, 7)) : 3'b000;
      equals[l]     = ($urandom_range(0, 2) == 0);
      op_sign[l]    = 1'($urandom_range(0, 1));
    end
  endtask

  // Decide this cycle's transfer from current inputs, then advance a cycle.
  task automatic go();
    #1;
    tb_load = in_valid && in_ready0 && !rst;
    if (tb_load) begin
      p_ev = 3'b000;
      p_n  = 0;
      for (int l = 0; l < 4; l++) begin
        p0[l*34 +: 34] = exp_lane(l, 0);
        p1[l*34 +: 34] = exp_lane(l, 1);
        if (lane_valid[l] && lane_mask[l]) begin
          case (cls(l))
            1: p_ev[1] = 1'b1;
            2: begin p_ev[2] = 1'b1; p_n++; end
            3: p_ev[0] = 1'b1;
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Reference state advances on each edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q0.delete(); q1.delete();
      m_flags = 3'b000;
      m_cnt = 0;
    end else begin
      if (q0.size() != 0 && out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (tb_load) begin
        q0.push_back(p0);
        q1.push_back(p1);
        m_flags = (clr_flags ? 3'b000 : m_flags) | p_ev;
        m_cnt = (clr_flags ? 0 : m_cnt) + p_n;
        if (m_cnt > 65535) m_cnt = 65535;
      end else if (clr_flags) begin
        m_flags = 3'b000;
        m_cnt = 0;
      end
    end
  end

  // Monitor: compares presented output against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (run && !rst) begin
      chk("out_valid0", 136'(out_valid0), 136'(q0.size() != 0));
      chk("out_valid1", 136'(out_valid1), 136'(q1.size() != 0));
      chk("in_ready0", 136'(in_ready0),
          136'((q0.size() == 0) || out_ready));
      if (q0.size() != 0) begin
        chk("data_mode0", out_data0, q0[0]);
        chk("data_mode1", out_data1, q1[0]);
      end
      chk("flags0", 136'(flags0), 136'(m_flags));
      chk("flags1", 136'(flags1), 136'(m_flags));
      chk("of_count0", 136'(of_count0), 136'(m_cnt));
      chk("of_count1", 136'(of_count1), 136'(m_cnt));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    defaults();
    @(posedge clk); @(posedge clk); #2;
    chk("rst_out_valid", 136'(out_valid0), 136'(0));
    chk("rst_out_data", out_data0, 136'(0));
    chk("rst_flags", 136'(flags0), 136'(0));
    chk("rst_of_count", 136'(of_count0), 136'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 136'(in_ready0), 136'(1));
    @(posedge clk); #2;
    run = 1'b1;

    // Denormal passthrough
    out_ready = 1'b1; in_valid = 1'b1;
    defaults();
    den_flag[0] = 1'b1; sa[0] = 1'b1; ma[23:0] = 24'h000400;
    go();
    chk("t1_lane0", 136'(lane_of(out_data0, 0)), 136'({2'b11, 32'h8000_0400}));
    chk("t1_flags", 136'(flags0), 136'(3'b010));

    // Overflow, both encodings
    defaults();
    inf_flag[5:3] = 3'b100;
    go();
    chk("t2_lane1_m0", 136'(lane_of(out_data0, 1)), 136'({2'b10, 32'h0}));
    chk("t2_lane1_m1", 136'(lane_of(out_data1, 1)), 136'({2'b11, 32'h7F80_0000}));
    chk("t2_of_flag", 136'(flags0[2]), 136'(1));
    chk("t2_of_count", 136'(of_count0), 136'(1));

    // Exact cancellation vs effective add
    defaults();
    equals[2] = 1'b1; result[2*31 +: 31] = 31'h3F80_0000;
    go();
    chk("t3_lane2_sub", 136'(lane_of(out_data0, 2)), 136'({2'b11, 32'h0}));
    chk("t3_flags_sub", 136'(flags0), 136'(3'b111));
    op_sign[2] = 1'b1;
    go();
    chk("t3_lane2_add", 136'(lane_of(out_data0, 2)), 136'({2'b11, 32'h3F80_0000}));
    chk("t3_flags_add", 136'(flags0), 136'(3'b111));

    // Random traffic with random backpressure and clears
    for (int i = 0; i < 400; i++) begin
      rand_group();
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_flags = ($urandom_range(0, 19) == 0);
      go();
    end
    clr_flags = 1'b0;

    // Backpressure: G1 held while G2 waits
    in_valid = 1'b0; out_ready = 1'b1;
    go();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_group();
    go();
    rand_group();
    for (int i = 0; i < 3; i++) begin
      chk("t4_in_ready_stall", 136'(in_ready0), 136'(0));
      go();
    end
    out_ready = 1'b1;
    go();
    in_valid = 1'b0;
    go();
    chk("t4_queue_empty", 136'(q0.size()), 136'(0));

    // Counter saturation and clear-with-load
    clr_flags = 1'b1;
    go();
    clr_flags = 1'b0;
    defaults();
    inf_flag = 12'h249;
    in_valid = 1'b1;
    for (int i = 0; i < 16383; i++) go();
    lane_mask = 4'b0011;
    go();
    chk("t5_cnt_fffe", 136'(of_count0), 136'(16'hFFFE));
    lane_mask = 4'hF;
    go();
    chk("t5_cnt_sat", 136'(of_count0), 136'(16'hFFFF));
    go();
    chk("t5_cnt_hold", 136'(of_count1), 136'(16'hFFFF));
    defaults();
    inf_flag[2:0] = 3'b010;
    clr_flags = 1'b1;
    go();
    clr_flags = 1'b0;
    chk("t5_clr_cnt", 136'(of_count0), 136'(1));
    chk("t5_clr_flags", 136'(flags0), 136'(3'b100));

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    go();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_out_valid0", 136'(out_valid0), 136'(0));
    chk("t6_out_valid1", 136'(out_valid1), 136'(0));
    chk("t6_flags", 136'(flags0), 136'(0));
    chk("t6_of_count", 136'(of_count0), 136'(0));
    chk("t6_out_data", out_data1, 136'(0));
    go();
    rst = 1'b0;
    #1;
    chk("t6_in_ready", 136'(in_ready0), 136'(1));
    out_ready = 1'b1;
    in_valid = 1'b1;
    rand_group();
    go();
    in_valid = 1'b0;
    go();
    go();
    chk("final_queue_empty", 136'(q0.size()), 136'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vfp_exception_stage.md
Name: vfp_exception_stage

Overview:
- Registered, multi-lane successor to the vector FP adder's single-lane combinational exception mux.
- Per lane, per element: selects the final result (denormal passthrough, infinity/overflow, exact cancellation, or normal result) and applies the lane mask.
- Accumulates sticky exception flags and a saturating overflow-event counter for CSR readout.
- Sits between the FP add/round pipeline and the vector register-file write port, behind a one-deep valid/ready pipeline register.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width; inputs carry the hidden bit, so they are MAN_W+1 wide.
- LANES, 4, number of parallel lanes.
- INF_MODE, 0, overflow encoding:
  - 0 = zero data with mask forced to 0, so the element is not written (legacy).
  - 1 = signed infinity, mask kept.
- CNT_W, 16, width of the overflow-event counter.

Ports:
(W = 1+EXP_W+MAN_W.)
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  element group valid.
- in_ready  out  1  stage can accept.
- lane_valid  in  LANES  per-lane valid bit.
- lane_mask  in  LANES  per-lane write mask.
- sa  in  LANES  operand A sign.
- ea  in  LANES*EXP_W  operand A exponent.
- ma  in  LANES*(MAN_W+1)  operand A mantissa with hidden bit.
- result  in  LANES*(W-1)  normal-path exponent+mantissa.
- den_flag  in  LANES  mixed normal/subnormal operation.
- dend_flag  in  LANES  both operands subnormal.
- inf_flag  in  LANES*3  {control, pre-rounder, rounder} infinity flags.
- equals  in  LANES  operand magnitudes equal.
- op_sign  in  LANES  effective operation (0 = subtract).
- out_valid  out  1  output group valid.
- out_ready  in  1  consumer accepts.
- out_data  out  LANES*(W+2)  per lane {valid, mask, value[W-1:0]}; lane 0 in the LSBs.
- flags  out  3  sticky {OF, DN, ZC}.
- of_count  out  CNT_W  saturating count of overflowed lanes.
- clr_flags  in  1  clears flags and of_count.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): out_valid=0, out_data=0, flags=0, of_count=0. Any in-flight group is dropped.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - load = in_valid & in_ready.
  - On load: out_data <= next value and out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Latency is 1 cycle. Full throughput with out_ready=1.
  - out_data is held stable while out_valid & ~out_ready.
- Per-lane select, first match wins (inf = OR of the 3 inf_flag bits):
  1. den & ~dend -> {lane_valid, mask, sa, ea, ma[MAN_W-1:0]}.
  2. inf:
     - INF_MODE=0 -> {1, 0, 0}.
     - INF_MODE=1 -> {1, mask, result-sign(sa), all-ones exponent, zero mantissa}.
  3. equals & ~op_sign -> {lane_valid, mask, W'b0}.
  4. otherwise -> {lane_valid, mask, sa, result}.
- Event qualification: events are counted only on load, only for lanes with lane_valid=1 and lane_mask=1. Priority order is the same as the select.
- Sticky flags: OF (priority-2 hit), DN (priority-1 hit), ZC (priority-3 hit). Each is OR-accumulated.
- of_count: adds the number of OF lanes in the loaded group (0..LANES) and saturates at 2^CNT_W-1 (no wrap).
- clr_flags:
  - clr_flags alone zeroes flags and of_count on the next edge.
  - clr_flags together with load: the result is clear-then-accumulate, so that cycle's events survive.
- Purely combinational in/out paths: only in_ready.

Test Plan:
1. Defaults; lane0 den=1, dend=0, sa=1, ea=0x00, ma=0x000400, mask=1 -> next cycle lane0 out = {1, 1, 0x80000400}; flags=3'b010.
2. lane1 inf_flag=3'b100, mask=1, INF_MODE=0 -> lane1 out = {1, 0, 0x00000000}; flags.OF=1; of_count=1. With INF_MODE=1 and sa=0 -> {1, 1, 0x7F800000}.
3. lane2 equals=1, op_sign=0, result=0x3F800000 -> lane2 data 0; ZC=1. Same with op_sign=1 -> 0x3F800000, ZC unchanged.
4. Backpressure: load group G1, out_ready=0 for 3 cycles, in_valid held with G2 -> in_ready=0 and out_data=G1 stable. Raise out_ready -> G2 appears on the next cycle with no loss or duplication.
5. of_count preloaded at 0xFFFE, group with 4 overflowed lanes -> 0xFFFF. clr_flags in the same cycle as a 1-OF group -> of_count=1, flags=3'b100.
6. Assert rst mid-stream with out_valid=1 -> out_valid, flags, and of_count are 0 immediately (before the next edge). After release, in_ready=1.
